// File: rtl/mult_booth_seq.sv
// rtl/mult_booth_seq.sv - multi-cycle radix-4 Booth multiplier with signed/unsigned mode and overflow flag
module mult_booth_seq #(
    parameter int WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     result,
    output logic                 ovf
);
    localparam int ITER = (WIDTH + 2) / 2;
    localparam int EW   = WIDTH + 2;
    localparam int AW   = 2 * WIDTH + 4;
    localparam int CW   = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            load;
    logic            step;
    logic            last;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   ma;
    logic [AW-1:0]   term;
    logic [AW-1:0]   acc_sum;
    logic            neg;
    logic [EW:0]     mq;
    logic            mode;
    logic [EW-1:0]   a_ext;
    logic [EW-1:0]   b_ext;

    // Two extra bits keep unsigned operands positive when viewed as Booth-signed
    assign a_ext  = signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
    assign b_ext  = signed_mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
    assign last   = (cnt == CW'(ITER - 1));
    assign result = product[WIDTH-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode; a start in DONE chains straight into CALC
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Booth recode of the current triplet; ma already carries the 4^i weight
    always_comb begin
        term = '0;
        neg  = 1'b0;
        case (mq[2:0])
            3'b001, 3'b010: term = ma;
            3'b011:         term = ma << 1;
            3'b100: begin
                term = ma << 1;
                neg  = 1'b1;
            end
            3'b101, 3'b110: begin
                term = ma;
                neg  = 1'b1;
            end
            default:        term = '0;
        endcase
        acc_sum = acc + (neg ? ~term : term) + {{(AW-1){1'b0}}, neg};
    end

    // Datapath: capture on accept, one shared add per step, publish on the final step
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            ma      <= '0;
            mq      <= '0;
            cnt     <= '0;
            mode    <= 1'b0;
            product <= '0;
            ovf     <= 1'b0;
        end else if (load) begin
            acc  <= '0;
            ma   <= {{(AW-EW){a_ext[EW-1]}}, a_ext};
            mq   <= {b_ext, 1'b0};
            cnt  <= '0;
            mode <= signed_mode;
        end else if (step) begin
            acc <= acc_sum;
            ma  <= ma << 2;
            mq  <= {2'b00, mq[EW:2]};
            cnt <= cnt + CW'(1);
            if (last) begin
                product <= acc_sum[2*WIDTH-1:0];
                if (mode) begin
                    ovf <= ~((&acc_sum[2*WIDTH-1:WIDTH-1]) | ~(|acc_sum[2*WIDTH-1:WIDTH-1]));
                end else begin
                    ovf <= |acc_sum[2*WIDTH-1:WIDTH];
                end
            end
        end
    end
endmodule

// File: tb/tb_mult_booth_seq.sv
// tb/tb_mult_booth_seq.sv - scoreboard bench for mult_booth_seq against an integer reference model
module tb_mult_booth_seq;
    localparam int W    = 12;
    localparam int ITER = 7;

    typedef struct {
        logic [2*W-1:0] prod;
        logic           ovf;
        int             dcyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             signed_mode;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;
    logic [W-1:0]     result;
    logic             ovf;

    int               n_vec = 0;
    int               n_err = 0;
    int               cyc = 0;
    logic             mon_en = 1'b0;
    logic             prev_done = 1'b0;
    logic [2*W-1:0]   held = '0;
    exp_t             q[$];

    mult_booth_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy), .done(done),
        .product(product), .result(result), .ovf(ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: true integer product, truncated to 2W bits; overflow when the
    // W-bit result cannot represent that product in the selected mode
    task automatic drive_op(input logic m, input logic [W-1:0] x, input logic [W-1:0] y);
        longint     sa;
        longint     sb;
        longint     p;
        logic [63:0] pv;
        exp_t       e;
        sa = m ? longint'($signed(x)) : longint'(x);
        sb = m ? longint'($signed(y)) : longint'(y);
        p  = sa * sb;
        pv = p;
        e.prod = pv[2*W-1:0];
        e.ovf  = m ? ((p < -(64'sd1 <<< (W-1))) || (p > (64'sd1 <<< (W-1)) - 1))
                   : (p > (64'sd1 <<< W) - 1);
        e.dcyc = cyc + 1 + ITER;
        q.push_back(e);
        start       = 1'b1;
        signed_mode = m;
        a           = x;
        b           = y;
    endtask

    // Issue one op and wait until the DUT sits in its DONE cycle; optionally
    // hammer start with junk operands while the op is busy
    task automatic run_op(input logic m, input logic [W-1:0] x, input logic [W-1:0] y, input bit spam);
        drive_op(m, x, y);
        for (int k = 0; k <= ITER; k++) begin
            @(posedge clk);
            #1;
            if (spam && k < ITER) begin
                start       = 1'b1;
                signed_mode = 1'($urandom);
                a           = W'($urandom);
                b           = W'($urandom);
            end else begin
                start = 1'b0;
            end
        end
    endtask

    // Monitor: pop the scoreboard on every done, otherwise require the output held
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (done) begin
                chk("done_width", 64'(prev_done), 64'd0);
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_done: got done=1 expected no pending op (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    chk("product", 64'(product), 64'(e.prod));
                    chk("result",  64'(result),  64'(e.prod[W-1:0]));
                    chk("ovf",     64'(ovf),     64'(e.ovf));
                    chk("latency", 64'(cyc),     64'(e.dcyc));
                    held = e.prod;
                end
            end else begin
                chk("hold", 64'(product), 64'(held));
            end
            if (rst) held = '0;
        end
        prev_done = done;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $finish;
    end

    initial begin
        rst         = 1'b1;
        start       = 1'b1;
        signed_mode = 1'b1;
        a           = 12'h5A5;
        b           = 12'h3C3;
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_busy",    64'(busy),    64'd0);
        chk("rst_done",    64'(done),    64'd0);
        chk("rst_product", 64'(product), 64'd0);
        chk("rst_ovf",     64'(ovf),     64'd0);
        mon_en = 1'b1;

        run_op(1'b1, 12'h800, 12'h800, 1'b0);
        run_op(1'b1, 12'hFFF, 12'h001, 1'b0);
        run_op(1'b0, 12'hFFF, 12'h001, 1'b0);
        run_op(1'b0, 12'hFFF, 12'hFFF, 1'b0);
        run_op(1'b1, 12'h7FF, 12'h002, 1'b0);
        run_op(1'b1, 12'h000, 12'hABC, 1'b0);
        run_op(1'b0, 12'h123, 12'h000, 1'b0);
        run_op(1'b0, 12'hABC, 12'hDEF, 1'b1);
        run_op(1'b1, 12'h9C3, 12'h5A5, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Abort an op mid-calculation
        drive_op(1'b1, 12'h7FF, 12'h7FF);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy",    64'(busy),    64'd0);
        chk("abort_product", 64'(product), 64'd0);
        repeat (ITER + 2) @(posedge clk);
        #1;
        run_op(1'b1, 12'h5A5, 12'h9C3, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            run_op(1'($urandom), W'($urandom), W'($urandom), 1'b0);
        end

        repeat (ITER + 3) @(posedge clk);
        #1;
        chk("drain", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
